fpu_cvt_sched: RTL and testbench

//  Shares the single FP->int convert pipe (cvt_FP_I_mod) between the three FPU lanes (u1/u3/u5) of
//  the low FPU cluster. Buffers per-lane convert requests, arbitrates round-robin and drives the pipe.

---
 rtl/fpu_cvt_sched_pkg.sv | 30 +++
 rtl/fpu_cvt_sched_lane_fifo.sv | 67 ++++++
 rtl/fpu_cvt_sched.sv | 157 +++++++++++++++
 tb/tb_fpu_cvt_sched.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fpu_cvt_sched_pkg.sv
// Shared types and fop codes for the low-cluster FP->int convert scheduler.
package fpu_cvt_sched_pkg;

   localparam int unsigned CVT_LANE_W = 2;
   localparam int unsigned CVT_TAGW   = 14;

   localparam logic [7:0] fop_cvtS   = 8'h40;
   localparam logic [7:0] fop_cvtD   = 8'h41;
   localparam logic [7:0] fop_cvtE   = 8'h42;
   localparam logic [7:0] fop_cvt32S = 8'h43;
   localparam logic [7:0] fop_cvt32D = 8'h44;
   localparam logic [7:0] fop_tblD   = 8'h45;

   typedef struct packed {
      logic                  vld;
      logic                  bad;
      logic [CVT_LANE_W-1:0] lane;
      logic [CVT_TAGW-1:0]   tag;
   } cvt_trk_t;

   function automatic logic fop_is_cvt(input logic [7:0] op);
      logic ok;
      case (op)
         fop_cvtS, fop_cvtD, fop_cvtE, fop_cvt32S, fop_cvt32D, fop_tblD: ok = 1'b1;
         default:                                                        ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/fpu_cvt_sched_lane_fifo.sv
// Per-lane request FIFO: DEPTH entries of {op,data,tag}; flush wins over a same-cycle push.
module fpu_cvt_lane_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned W     = 90
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign dout    = mem_q[rd_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (flush) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_q] = din;
            wr_d        = wr_q + AW'(1);
         end
         if (do_pop) rd_d = rd_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fpu_cvt_sched.sv
// Shares the FP->int convert pipe between lanes u1/u3/u5: per-lane FIFOs, round-robin
// issue, a latency tracker that freezes with the pipe, and a registered return port.
module fpu_cvt_sched
   import fpu_cvt_sched_pkg::*;
#(
   parameter int unsigned NREQ  = 3,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned LAT   = 2,
   parameter int unsigned TAGW  = CVT_TAGW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic [NREQ-1:0]      req_vld,
   input  logic [NREQ*8-1:0]    req_op,
   input  logic [NREQ*68-1:0]   req_data,
   input  logic [NREQ*TAGW-1:0] req_tag,
   output logic [NREQ-1:0]      req_rdy,
   input  logic                 stall,
   output logic                 cvt_en,
   output logic [7:0]           cvt_op,
   output logic [67:0]          cvt_A,
   output logic                 cvt_clkEn,
   input  logic [64:0]          cvt_res,
   input  logic                 cvt_alt,
   output logic                 ret_vld,
   output logic [1:0]           ret_lane,
   output logic [TAGW-1:0]      ret_tag,
   output logic [64:0]          ret_res,
   output logic                 ret_alt
);
   localparam int unsigned EW = 8 + 68 + TAGW;

   logic [EW-1:0]         head_e [NREQ];
   logic [NREQ-1:0]       full, empty, push, pop;
   logic [CVT_LANE_W-1:0] rr_q, rr_d, grant;
   logic                  found, issue, legal;
   logic [EW-1:0]         head;
   logic [7:0]            head_op;
   logic [67:0]           head_data;
   logic [TAGW-1:0]       head_tag;
   cvt_trk_t              trk_q [LAT];
   cvt_trk_t              trk_d [LAT];
   cvt_trk_t              trk_last;
   logic                  ret_vld_q, ret_vld_d, ret_alt_q, ret_alt_d;
   logic [1:0]            ret_lane_q, ret_lane_d;
   logic [TAGW-1:0]       ret_tag_q, ret_tag_d;
   logic [64:0]           ret_res_q, ret_res_d;

   for (genvar g = 0; g < NREQ; g++) begin : g_lane
      assign push[g] = req_vld[g] && !full[g];
      assign pop[g]  = issue && (grant == CVT_LANE_W'(g));
      fpu_cvt_lane_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
         .clk  (clk),
         .rst  (rst),
         .flush(flush),
         .push (push[g]),
         .pop  (pop[g]),
         .din  ({req_op[g*8 +: 8], req_data[g*68 +: 68], req_tag[g*TAGW +: TAGW]}),
         .dout (head_e[g]),
         .full (full[g]),
         .empty(empty[g])
      );
   end

   assign req_rdy = ~full;

   always_comb begin
      grant = rr_q;
      found = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         int unsigned idx;
         idx = (32'(rr_q) + k) % NREQ;
         if (!found && !empty[idx]) begin
            found = 1'b1;
            grant = CVT_LANE_W'(idx);
         end
      end
   end

   assign issue     = !stall && !flush && found;
   assign head      = head_e[grant];
   assign head_op   = head[EW-1 -: 8];
   assign head_data = head[TAGW +: 68];
   assign head_tag  = head[TAGW-1:0];
   assign legal     = fop_is_cvt(head_op);

   // Illegal ops still pop and occupy a tracker slot, but never reach the pipe.
   assign cvt_en    = issue && legal;
   assign cvt_op    = cvt_en ? head_op : '0;
   assign cvt_A     = cvt_en ? head_data : '0;
   assign cvt_clkEn = !stall;

   always_comb begin
      rr_d = rr_q;
      if (issue) rr_d = (32'(grant) == NREQ - 1) ? '0 : grant + CVT_LANE_W'(1);
   end

   always_comb begin
      trk_d = trk_q;
      if (flush) begin
         for (int unsigned i = 0; i < LAT; i++) trk_d[i].vld = 1'b0;
      end else if (!stall) begin
         for (int unsigned i = LAT - 1; i > 0; i--) trk_d[i] = trk_q[i-1];
         trk_d[0] = '0;
         if (issue) begin
            trk_d[0].vld  = 1'b1;
            trk_d[0].bad  = !legal;
            trk_d[0].lane = grant;
            trk_d[0].tag  = CVT_TAGW'(head_tag);
         end
      end
   end

   assign trk_last = trk_q[LAT-1];

   always_comb begin
      ret_vld_d  = !stall && !flush && trk_last.vld;
      ret_lane_d = ret_lane_q;
      ret_tag_d  = ret_tag_q;
      ret_res_d  = ret_res_q;
      ret_alt_d  = ret_alt_q;
      if (ret_vld_d) begin
         ret_lane_d = trk_last.lane;
         ret_tag_d  = TAGW'(trk_last.tag);
         ret_res_d  = trk_last.bad ? '0 : cvt_res;
         ret_alt_d  = trk_last.bad ? 1'b1 : cvt_alt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_q <= '0;
         for (int unsigned i = 0; i < LAT; i++) trk_q[i] <= '0;
         ret_vld_q  <= 1'b0;
         ret_lane_q <= '0;
         ret_tag_q  <= '0;
         ret_res_q  <= '0;
         ret_alt_q  <= 1'b0;
      end else begin
         rr_q       <= rr_d;
         trk_q      <= trk_d;
         ret_vld_q  <= ret_vld_d;
         ret_lane_q <= ret_lane_d;
         ret_tag_q  <= ret_tag_d;
         ret_res_q  <= ret_res_d;
         ret_alt_q  <= ret_alt_d;
      end
   end

   assign ret_vld  = ret_vld_q;
   assign ret_lane = ret_lane_q;
   assign ret_tag  = ret_tag_q;
   assign ret_res  = ret_res_q;
   assign ret_alt  = ret_alt_q;

endmodule

// File: tb/tb_fpu_cvt_sched.sv
// Directed bench for fpu_cvt_sched with a 2-stage convert pipe stand-in (result = A+1).
module tb_fpu_cvt_sched;
   import fpu_cvt_sched_pkg::*;

   logic         clk = 1'b0;
   logic         rst, flush, stall;
   logic [2:0]   req_vld, req_rdy;
   logic [23:0]  req_op;
   logic [203:0] req_data;
   logic [41:0]  req_tag;
   logic         cvt_en, cvt_clkEn, cvt_alt, ret_vld, ret_alt;
   logic [7:0]   cvt_op;
   logic [67:0]  cvt_A;
   logic [64:0]  cvt_res, ret_res;
   logic [1:0]   ret_lane;
   logic [13:0]  ret_tag;

   logic [64:0]  p0_q, p1_q;
   logic         a0_q, a1_q;
   int           n_chk = 0;
   int           n_pass = 0;
   int           seen;

   always #5 clk = ~clk;

   fpu_cvt_sched #(.NREQ(3), .DEPTH(2), .LAT(2), .TAGW(14)) dut (
      .clk(clk), .rst(rst), .flush(flush), .req_vld(req_vld), .req_op(req_op),
      .req_data(req_data), .req_tag(req_tag), .req_rdy(req_rdy), .stall(stall),
      .cvt_en(cvt_en), .cvt_op(cvt_op), .cvt_A(cvt_A), .cvt_clkEn(cvt_clkEn),
      .cvt_res(cvt_res), .cvt_alt(cvt_alt), .ret_vld(ret_vld), .ret_lane(ret_lane),
      .ret_tag(ret_tag), .ret_res(ret_res), .ret_alt(ret_alt)
   );

   // Bubbles leave junk in the pipe so the DUT must force ret_res/ret_alt itself.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         p0_q <= '0; p1_q <= '0; a0_q <= 1'b0; a1_q <= 1'b0;
      end else if (cvt_clkEn) begin
         p0_q <= cvt_en ? cvt_A[64:0] + 65'd1 : 65'h5A5A;
         a0_q <= cvt_en ? cvt_A[67] : 1'b0;
         p1_q <= p0_q;
         a1_q <= a0_q;
      end
   end
   assign cvt_res = p1_q;
   assign cvt_alt = a1_q;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int l, input logic [7:0] op, input logic [67:0] d, input logic [13:0] t);
      req_vld[l]           = 1'b1;
      req_op[l*8 +: 8]     = op;
      req_data[l*68 +: 68] = d;
      req_tag[l*14 +: 14]  = t;
   endtask

   task automatic quiet(input int n, input string tag);
      int cnt;
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         nxt();
         #1;
         if (ret_vld || cvt_en) cnt++;
      end
      chk(tag, cnt, 0);
   endtask

   task automatic chk_ret(input string tag, input logic [13:0] t, input logic [1:0] l,
                          input logic [64:0] r, input logic a);
      chk({tag, "_vld"}, ret_vld, 1'b1);
      chk({tag, "_tag"}, ret_tag, t);
      chk({tag, "_lane"}, ret_lane, l);
      chk({tag, "_res"}, ret_res, r);
      chk({tag, "_alt"}, ret_alt, a);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; flush = 1'b0; stall = 1'b0;
      req_vld = '0; req_op = '0; req_data = '0; req_tag = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ret_vld", ret_vld, 1'b0);
      chk("rst_cvt_en", cvt_en, 1'b0);
      chk("rst_rdy", req_rdy, 3'b111);
      rst = 1'b1;

      // 1: reset in the middle of traffic
      nxt(); stall = 1'b1;
      put(0, fop_cvtS, 68'h100, 14'd20); put(1, fop_cvtS, 68'h101, 14'd21); put(2, fop_cvtS, 68'h102, 14'd22);
      nxt(); req_vld = '0; stall = 1'b0; #1;
      chk("t1_issue", cvt_en, 1'b1);
      nxt(); rst = 1'b0; #1;
      chk("t1_async_en", cvt_en, 1'b0);
      nxt();
      chk("t1_ret_vld", ret_vld, 1'b0);
      chk("t1_cvt_en", cvt_en, 1'b0);
      chk("t1_rdy", req_rdy, 3'b111);
      rst = 1'b1;
      quiet(8, "t1_lost");

      // 2: three lanes at once, round-robin from lane0
      nxt();
      put(0, fop_cvtD, 68'h1001, 14'd1); put(1, fop_cvtD, 68'h1002, 14'd2); put(2, fop_cvtD, 68'h1003, 14'd3);
      #1;
      chk("t2_rdy", req_rdy, 3'b111);
      chk("t2_no_issue", cvt_en, 1'b0);
      nxt(); req_vld = '0; #1;
      chk("t2_en0", cvt_en, 1'b1);
      chk("t2_op0", cvt_op, fop_cvtD);
      chk("t2_A0", cvt_A, 68'h1001);
      nxt(); #1; chk("t2_A1", cvt_A, 68'h1002);
      nxt(); #1; chk("t2_A2", cvt_A, 68'h1003);
      nxt(); #1;
      chk("t2_idle", cvt_en, 1'b0);
      chk_ret("t2_r1", 14'd1, 2'd0, 65'h1002, 1'b0);
      nxt(); #1; chk_ret("t2_r2", 14'd2, 2'd1, 65'h1003, 1'b0);
      nxt(); #1; chk_ret("t2_r3", 14'd3, 2'd2, 65'h1004, 1'b0);
      nxt(); #1; chk("t2_end", ret_vld, 1'b0);

      // 3: fill lane2 under stall, third push held by the source
      nxt(); stall = 1'b1; put(2, fop_cvt32D, 68'h8_0000_0000_0000_0200, 14'd30); #1;
      chk("t3_rdy_a", req_rdy[2], 1'b1);
      nxt(); put(2, fop_cvt32D, 68'h8_0000_0000_0000_0201, 14'd31); #1;
      chk("t3_rdy_b", req_rdy[2], 1'b1);
      nxt(); put(2, fop_cvt32D, 68'h8_0000_0000_0000_0202, 14'd32); #1;
      chk("t3_full", req_rdy[2], 1'b0);
      chk("t3_stall_en", cvt_en, 1'b0);
      chk("t3_clken", cvt_clkEn, 1'b0);
      nxt(); stall = 1'b0; #1;
      chk("t3_full_pop", req_rdy[2], 1'b0);
      chk("t3_A30", cvt_A, 68'h8_0000_0000_0000_0200);
      nxt(); #1;
      chk("t3_rdy_c", req_rdy[2], 1'b1);
      chk("t3_A31", cvt_A, 68'h8_0000_0000_0000_0201);
      nxt(); req_vld = '0; #1;
      chk("t3_A32", cvt_A, 68'h8_0000_0000_0000_0202);
      nxt(); #1; chk_ret("t3_r30", 14'd30, 2'd2, 65'h201, 1'b1);
      nxt(); #1; chk_ret("t3_r31", 14'd31, 2'd2, 65'h202, 1'b1);
      nxt(); #1; chk_ret("t3_r32", 14'd32, 2'd2, 65'h203, 1'b1);

      // 4: four stall cycles delay the return by exactly four
      nxt(); put(0, fop_cvtE, 68'h500, 14'd5);
      nxt(); req_vld = '0; #1;
      chk("t4_issue", cvt_en, 1'b1);
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         nxt(); stall = 1'b1; #1;
         if (ret_vld) seen++;
      end
      chk("t4_clken", cvt_clkEn, 1'b0);
      nxt(); stall = 1'b0; #1;
      if (ret_vld) seen++;
      nxt(); #1;
      if (ret_vld) seen++;
      chk("t4_early", seen, 0);
      nxt(); #1; chk_ret("t4_r5", 14'd5, 2'd0, 65'h501, 1'b0);
      nxt(); #1; chk("t4_single", ret_vld, 1'b0);

      // 5: illegal op is a bubble that still returns with alt set
      nxt(); put(1, 8'hFF, 68'h777, 14'd9);
      nxt(); req_vld = '0; #1;
      chk("t5_no_en", cvt_en, 1'b0);
      nxt(); nxt();
      nxt(); #1; chk_ret("t5_r9", 14'd9, 2'd1, 65'h0, 1'b1);

      // 6: flush with two in flight, one queued and a same-cycle push
      nxt();
      put(0, fop_cvtS, 68'h40, 14'd40); put(1, fop_cvtS, 68'h41, 14'd41); put(2, fop_cvtS, 68'h42, 14'd42);
      nxt(); req_vld = '0; #1;
      chk("t6_rr_lane2", cvt_A, 68'h42);
      nxt(); #1;
      chk("t6_rr_lane0", cvt_A, 68'h40);
      nxt(); flush = 1'b1; put(0, fop_cvtS, 68'h43, 14'd43); #1;
      chk("t6_flush_en", cvt_en, 1'b0);
      nxt(); flush = 1'b0; req_vld = '0; #1;
      chk("t6_ret", ret_vld, 1'b0);
      chk("t6_rdy", req_rdy, 3'b111);
      quiet(8, "t6_quiet");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
